// File: rtl/wb_bridge_pkg.sv
// Shared constants for the Wishbone bridges.
//   Bridge state encoding: IDLE, REQ, WAIT, ACK, ABORT.
//   Wishbone B4 cycle-type (CTI) and burst-type (BTE) codes.
package wb_bridge_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_REQ   = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_ACK   = 3'd3;
  localparam logic [STATE_W-1:0] ST_ABORT = 3'd4;

  localparam int unsigned CTI_W = 3;
  localparam int unsigned BTE_W = 2;

  localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
  localparam logic [CTI_W-1:0] CTI_CONST   = 3'b001;
  localparam logic [CTI_W-1:0] CTI_INCR    = 3'b010;
  localparam logic [CTI_W-1:0] CTI_EOB     = 3'b111;

  localparam logic [BTE_W-1:0] BTE_LINEAR = 2'b00;
  localparam logic [BTE_W-1:0] BTE_WRAP4  = 2'b01;
  localparam logic [BTE_W-1:0] BTE_WRAP8  = 2'b10;
  localparam logic [BTE_W-1:0] BTE_WRAP16 = 2'b11;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating response-timeout counter.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : restart the count from zero (has priority over enable)
//   enable       : count up by one, saturating at 2^LGTIMEOUT-1
//   expired_c    : count has reached its ceiling (constant 0 when LGTIMEOUT==0)
module wb_timeout_ctr #(
  parameter int unsigned LGTIMEOUT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  if (LGTIMEOUT == 0) begin : g_off
    // Timeout disabled: nothing to count.
    logic unused_ctr;
    assign unused_ctr = ^{clk, reset_n, clear, enable};
    assign expired_c  = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = LGTIMEOUT;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        count <= '0;
      end else if (clear) begin
        count <= '0;
      end else if (enable && (count != CNT_MAX)) begin
        count <= count + CW'(1);
      end
    end

    assign expired_c = (count == CNT_MAX);
  end

endmodule

// File: rtl/wbc2pipeline.sv
// Wishbone B4 classic master -> pipelined slave bridge with response timeout.
//   Classic side  : i_scyc/i_sstb/i_swe/i_saddr/i_sdata/i_ssel/i_scti/i_sbte in,
//                   o_sack/o_serr/o_sdata out (single-cycle ack or err).
//   Pipelined side: o_mcyc/o_mstb/o_mwe/o_maddr/o_mdata/o_msel out,
//                   i_mstall/i_mack/i_mdata/i_merr in.
//   One pipelined request per classic strobe; LGTIMEOUT bounds the wait
//   from issue to response (0 disables it).
module wbc2pipeline
  import wb_bridge_pkg::*;
#(
  parameter int unsigned AW        = 12,
  parameter int unsigned DW        = 32,
  parameter int unsigned LGTIMEOUT = 8
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_scyc,
  input  logic            i_sstb,
  input  logic            i_swe,
  input  logic [AW-1:0]   i_saddr,
  input  logic [DW-1:0]   i_sdata,
  input  logic [DW/8-1:0] i_ssel,
  input  logic [2:0]      i_scti,
  input  logic [1:0]      i_sbte,
  output logic            o_sack,
  output logic            o_serr,
  output logic [DW-1:0]   o_sdata,
  output logic            o_mcyc,
  output logic            o_mstb,
  output logic            o_mwe,
  output logic [AW-1:0]   o_maddr,
  output logic [DW-1:0]   o_mdata,
  output logic [DW/8-1:0] o_msel,
  input  logic            i_mstall,
  input  logic            i_mack,
  input  logic [DW-1:0]   i_mdata,
  input  logic            i_merr
);

  logic [STATE_W-1:0] state, state_nxt;
  logic               mstb_r, mstb_nxt;
  logic               sack_nxt, serr_nxt;
  logic [DW-1:0]      sdata_nxt;
  logic               ctr_clear_c, ctr_en_c, expired_c;

  // Every beat is treated as classic; burst hints are deliberately ignored.
  logic unused_burst;
  assign unused_burst = ^{i_scti == CTI_CLASSIC, i_scti == CTI_CONST,
                          i_scti == CTI_INCR,    i_scti == CTI_EOB,
                          i_sbte == BTE_LINEAR,  i_sbte == BTE_WRAP4,
                          i_sbte == BTE_WRAP8,   i_sbte == BTE_WRAP16};

  // Classic master holds these stable until ack, so they pass straight through.
  assign o_mwe   = i_swe;
  assign o_maddr = i_saddr;
  assign o_mdata = i_sdata;
  assign o_msel  = i_ssel;

  // Dropping cyc (classic abort, reset or timeout flush) discards any
  // outstanding pipelined response in the same cycle.
  assign o_mcyc = i_reset_n && i_scyc && (state != ST_ABORT);
  // Gate the registered strobe so it can never be seen without cyc.
  assign o_mstb = mstb_r && o_mcyc;

  wb_timeout_ctr #(
    .LGTIMEOUT(LGTIMEOUT)
  ) u_timeout (
    .clk      (i_clk),
    .reset_n  (i_reset_n),
    .clear    (ctr_clear_c),
    .enable   (ctr_en_c),
    .expired_c(expired_c)
  );

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state   <= ST_IDLE;
      mstb_r  <= 1'b0;
      o_sack  <= 1'b0;
      o_serr  <= 1'b0;
      o_sdata <= '0;
    end else begin
      state   <= state_nxt;
      mstb_r  <= mstb_nxt;
      o_sack  <= sack_nxt;
      o_serr  <= serr_nxt;
      o_sdata <= sdata_nxt;
    end
  end

  // Next state and next registered outputs; ack/err default low so they pulse.
  always_comb begin
    state_nxt   = state;
    mstb_nxt    = mstb_r;
    sack_nxt    = 1'b0;
    serr_nxt    = 1'b0;
    sdata_nxt   = o_sdata;
    ctr_clear_c = 1'b0;
    ctr_en_c    = 1'b0;

    if (!i_scyc) begin
      state_nxt = ST_IDLE;
      mstb_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_sstb) begin
            state_nxt   = ST_REQ;
            mstb_nxt    = 1'b1;
            ctr_clear_c = 1'b1;
          end
        end
        ST_REQ: begin
          ctr_en_c = 1'b1;
          if (expired_c) begin
            serr_nxt  = 1'b1;
            mstb_nxt  = 1'b0;
            state_nxt = ST_ABORT;
          end else if (!i_mstall) begin
            mstb_nxt  = 1'b0;
            state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          ctr_en_c = 1'b1;
          // A response arriving on the expiry cycle still wins; err beats ack.
          if (i_mack || i_merr) begin
            sack_nxt  = i_mack && !i_merr;
            serr_nxt  = i_merr;
            sdata_nxt = i_mdata;
            state_nxt = ST_ACK;
          end else if (expired_c) begin
            serr_nxt  = 1'b1;
            state_nxt = ST_ABORT;
          end
        end
        ST_ACK:   state_nxt = ST_IDLE;
        ST_ABORT: state_nxt = ST_IDLE;
        default: begin
          state_nxt = ST_IDLE;
          mstb_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbc2pipeline.sv
// Randomized self-checking bench for wbc2pipeline (LGTIMEOUT = 4).
// Each transaction's timeline (issue, acceptance, response or timeout,
// abort) is planned arithmetically; per-cycle expectations follow from it
// and one compare process checks them on every falling edge.
module tb_wbc2pipeline;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned LGT = 4;
  localparam int          T   = (1 << LGT) - 1;

  logic            clk = 1'b0;
  logic            i_reset_n, i_scyc, i_sstb, i_swe;
  logic [AW-1:0]   i_saddr;
  logic [DW-1:0]   i_sdata;
  logic [SW-1:0]   i_ssel;
  logic [2:0]      i_scti;
  logic [1:0]      i_sbte;
  logic            o_sack, o_serr;
  logic [DW-1:0]   o_sdata;
  logic            o_mcyc, o_mstb, o_mwe;
  logic [AW-1:0]   o_maddr;
  logic [DW-1:0]   o_mdata;
  logic [SW-1:0]   o_msel;
  logic            i_mstall, i_mack, i_merr;
  logic [DW-1:0]   i_mdata;

  always #5 clk = ~clk;

  wbc2pipeline #(.AW(AW), .DW(DW), .LGTIMEOUT(LGT)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .i_scyc(i_scyc), .i_sstb(i_sstb), .i_swe(i_swe),
    .i_saddr(i_saddr), .i_sdata(i_sdata), .i_ssel(i_ssel),
    .i_scti(i_scti), .i_sbte(i_sbte),
    .o_sack(o_sack), .o_serr(o_serr), .o_sdata(o_sdata),
    .o_mcyc(o_mcyc), .o_mstb(o_mstb), .o_mwe(o_mwe),
    .o_maddr(o_maddr), .o_mdata(o_mdata), .o_msel(o_msel),
    .i_mstall(i_mstall), .i_mack(i_mack), .i_mdata(i_mdata), .i_merr(i_merr)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_now  = 0;
  int t_start  = 0;
  bit check_en = 1'b0;

  logic          exp_mstb, exp_sack, exp_serr, exp_mcyc;
  logic [DW-1:0] exp_sdata;
  logic [DW-1:0] model_sdata;

  int mstb_cnt, sack_cnt, serr_cnt, sack_off, serr_off, mcyc_low_cnt;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_now);
    end
  endtask

  task automatic clr_rec();
    mstb_cnt = 0; sack_cnt = 0; serr_cnt = 0;
    sack_off = -1; serr_off = -1; mcyc_low_cnt = 0;
  endtask

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("mcyc",  DW'(o_mcyc), DW'(exp_mcyc));
      chk("mstb",  DW'(o_mstb), DW'(exp_mstb));
      chk("sack",  DW'(o_sack), DW'(exp_sack));
      chk("serr",  DW'(o_serr), DW'(exp_serr));
      chk("sdata", o_sdata, exp_sdata);
      chk("mwe",   DW'(o_mwe),   DW'(i_swe));
      chk("maddr", DW'(o_maddr), DW'(i_saddr));
      chk("mdata", o_mdata, i_sdata);
      chk("msel",  DW'(o_msel),  DW'(i_ssel));
      if (o_mstb) mstb_cnt++;
      if (o_sack) begin sack_cnt++; sack_off = cyc_now - t_start; end
      if (o_serr) begin serr_cnt++; serr_off = cyc_now - t_start; end
      if (i_reset_n && i_scyc && !o_mcyc) mcyc_low_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc_now++;
  endtask

  task automatic set_quiet_exp(input logic mcyc);
    exp_mstb  = 1'b0;
    exp_sack  = 1'b0;
    exp_serr  = 1'b0;
    exp_mcyc  = mcyc;
    exp_sdata = model_sdata;
  endtask

  // Classic bus idle; pipelined responses are random noise that must be ignored.
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      step();
      i_reset_n = 1'b1;
      i_scyc    = 1'b0;
      i_sstb    = 1'($urandom);
      i_mstall  = 1'($urandom);
      i_mack    = 1'($urandom);
      i_merr    = 1'($urandom % 4 == 0);
      i_mdata   = DW'($urandom);
      set_quiet_exp(1'b0);
    end
  endtask

  // One classic transaction. s: stall cycles, d: slave wait cycles after
  // acceptance. kind: 0 normal, 1 classic abort at issue-relative cycle ab,
  // 2 reset at cycle ab. Issue-relative cycle n=0 is the first o_mstb cycle.
  task automatic txn(input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input logic [SW-1:0] sel,
                     input int s, input int d, input bit err, input bit both,
                     input int kind, input int ab, input logic [DW-1:0] rd);
    bit to, stop;
    int resp_n, done_n, last_n, mstb_last;
    resp_n    = s + 1 + d;
    to        = (s >= T) || (resp_n > T);
    done_n    = to ? T + 1 : resp_n + 1;
    mstb_last = (s < T) ? s : T;
    last_n    = (kind != 0) ? ab : done_n;

    step();
    t_start   = cyc_now;
    i_reset_n = 1'b1;
    i_scyc = 1'b1; i_sstb = 1'b1; i_swe = we;
    i_saddr = addr; i_sdata = wd; i_ssel = sel;
    i_scti = 3'($urandom); i_sbte = 2'($urandom);
    i_mstall = 1'($urandom); i_mack = 1'($urandom); i_merr = 1'b0;
    i_mdata = DW'($urandom);
    set_quiet_exp(1'b1);

    for (int n = 0; n <= last_n; n++) begin
      step();
      stop      = (kind != 0) && (n == ab);
      i_scyc    = !(stop && kind == 1);
      i_sstb    = i_scyc;
      i_reset_n = !(stop && kind == 2);
      i_mstall  = (n < s) ? 1'b1 : (n == s) ? 1'b0 : 1'($urandom);
      i_mdata   = DW'($urandom);
      i_mack    = 1'b0;
      i_merr    = 1'b0;
      if (!to && n == resp_n) begin
        i_mack  = !err || both;
        i_merr  = err;
        i_mdata = rd;
      end else if (n <= mstb_last || (to && n == done_n)) begin
        i_mack = 1'($urandom);
        i_merr = 1'($urandom % 4 == 0);
      end
      if (stop) begin
        set_quiet_exp(1'b0);
      end else begin
        if (n == done_n && !to) model_sdata = rd;
        exp_mstb  = (n <= mstb_last);
        exp_sack  = (n == done_n) && !to && !err;
        exp_serr  = (n == done_n) && (to || err);
        exp_mcyc  = !((n == done_n) && to);
        exp_sdata = model_sdata;
      end
    end

    if (kind != 0) begin
      if (kind == 2) model_sdata = '0;
      for (int p = 0; p < 2; p++) begin
        step();
        i_reset_n = 1'b1;
        i_scyc = 1'b0; i_sstb = 1'b0;
        i_mack = (p == 1);
        i_merr = 1'b0;
        set_quiet_exp(1'b0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s, d, kind, ab, resp_n, done_n;
    bit err, both;
    i_reset_n = 1'b0; i_scyc = 1'b0; i_sstb = 1'b0; i_swe = 1'b0;
    i_saddr = '0; i_sdata = '0; i_ssel = '0; i_scti = '0; i_sbte = '0;
    i_mstall = 1'b0; i_mack = 1'b0; i_merr = 1'b0; i_mdata = '0;
    model_sdata = '0;
    clr_rec();

    // Reset state.
    step();
    set_quiet_exp(1'b0);
    check_en = 1'b1;
    idle(2);

    // 1: single read, no stall, slave acks one cycle after issue.
    clr_rec();
    txn(1'b0, 12'h123, 32'h0, 4'hF, 0, 0, 1'b0, 1'b0, 0, 0, 32'hDEADBEEF);
    idle(1);
    chk("t1_mstb_cycles", DW'(mstb_cnt), 32'd1);
    chk("t1_sack_count",  DW'(sack_cnt), 32'd1);
    chk("t1_sack_cycle",  DW'(sack_off), 32'd3);
    chk("t1_sdata",       o_sdata, 32'hDEADBEEF);

    // 2: write stalled three cycles.
    clr_rec();
    txn(1'b1, 12'h2A5, 32'h5A5A5A5A, 4'hF, 3, 1, 1'b0, 1'b0, 0, 0, 32'h0BADF00D);
    idle(1);
    chk("t2_mstb_cycles", DW'(mstb_cnt), 32'd4);
    chk("t2_sack_count",  DW'(sack_cnt), 32'd1);
    chk("t2_sack_cycle",  DW'(sack_off), 32'd7);

    // 3: back-to-back strobes.
    clr_rec();
    txn(1'b0, 12'h010, 32'h0, 4'h3, 0, 0, 1'b0, 1'b0, 0, 0, 32'h11112222);
    txn(1'b0, 12'h011, 32'h0, 4'hC, 1, 0, 1'b0, 1'b0, 0, 0, 32'h33334444);
    idle(1);
    chk("t3_sack_count",  DW'(sack_cnt), 32'd2);
    chk("t3_mstb_cycles", DW'(mstb_cnt), 32'd3);

    // 4: err together with ack; err wins and data is still latched.
    clr_rec();
    txn(1'b0, 12'h0E0, 32'h0, 4'hF, 0, 2, 1'b1, 1'b1, 0, 0, 32'hBAD0BAD0);
    idle(1);
    chk("t4_serr_count", DW'(serr_cnt), 32'd1);
    chk("t4_sack_count", DW'(sack_cnt), 32'd0);
    chk("t4_sdata",      o_sdata, 32'hBAD0BAD0);

    // 5: classic abort in WAIT, late ack, then a normal transaction.
    clr_rec();
    txn(1'b0, 12'h055, 32'h0, 4'hF, 1, 5, 1'b0, 1'b0, 1, 3, 32'hFFFF0000);
    chk("t5_abort_no_sack", DW'(sack_cnt), 32'd0);
    chk("t5_abort_no_serr", DW'(serr_cnt), 32'd0);
    txn(1'b1, 12'h056, 32'hCAFEF00D, 4'hF, 0, 1, 1'b0, 1'b0, 0, 0, 32'h12345678);
    idle(1);
    chk("t5_next_sack", DW'(sack_cnt), 32'd1);

    // 6: slave never answers; timeout, one ABORT cycle, late ack ignored.
    clr_rec();
    txn(1'b0, 12'h777, 32'h0, 4'hF, 0, 40, 1'b0, 1'b0, 0, 0, 32'h0);
    idle(3);
    chk("t6_serr_count", DW'(serr_cnt), 32'd1);
    chk("t6_serr_cycle", DW'(serr_off), 32'd17);
    chk("t6_abort_len",  DW'(mcyc_low_cnt), 32'd1);
    chk("t6_sack_count", DW'(sack_cnt), 32'd0);

    // Reset asserted mid-WAIT.
    txn(1'b0, 12'h3C3, 32'h0, 4'hF, 0, 10, 1'b0, 1'b0, 2, 4, 32'h0);
    chk("rst_sdata", o_sdata, 32'h0);

    // Randomized transactions, including timeouts, errors and aborts.
    for (int i = 0; i < 60; i++) begin
      s    = ($urandom % 6 == 0) ? int'($urandom_range(10, 17)) : int'($urandom_range(0, 3));
      d    = ($urandom % 5 == 0) ? int'($urandom_range(8, 18)) : int'($urandom_range(0, 4));
      err  = ($urandom % 4 == 0);
      both = 1'($urandom);
      resp_n = s + 1 + d;
      done_n = ((s >= T) || (resp_n > T)) ? T + 1 : resp_n + 1;
      kind = ($urandom % 6 == 0) ? int'($urandom_range(1, 2)) : 0;
      ab   = int'($urandom_range(0, done_n - 1));
      txn(1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom),
          s, d, err, both, kind, ab, DW'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wbc2pipeline.md
Name: wbc2pipeline

Overview:
- Bridge from a Wishbone B4 *classic* master (e.g. a legacy CPU or DMA) to a Wishbone *pipelined* slave/interconnect port.
- Each classic strobe becomes exactly one pipelined request. The block waits for that request's response, then returns a single-cycle classic ack or err.
- Adds a response timeout so a dead pipelined slave cannot hang the classic master.

Parameters:
- AW, 12, address width (word addressed)
- DW, 32, data width; multiple of 8
- LGTIMEOUT, 8, log2 of the cycle budget from request issue to response. 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_scyc, i_sstb, i_swe  in  1 each  classic master cycle, strobe and write-enable
- i_saddr  in  AW  classic address
- i_sdata  in  DW  classic write data
- i_ssel  in  DW/8  classic byte selects
- i_scti  in  3  cycle type; accepted, not acted on (every beat is handled as a classic cycle)
- i_sbte  in  2  burst type; accepted, ignored
- o_sack  out  1  classic ack
- o_serr  out  1  classic error
- o_sdata  out  DW  classic read data
- o_mcyc, o_mstb, o_mwe  out  1 each  pipelined cycle, strobe and write-enable
- o_maddr  out  AW  pipelined address
- o_mdata  out  DW  pipelined write data
- o_msel  out  DW/8  pipelined byte selects
- i_mstall  in  1  pipelined stall
- i_mack  in  1  pipelined ack
- i_mdata  in  DW  pipelined read data
- i_merr  in  1  pipelined error

Behaviour:
- Reset (i_reset_n low at a clock edge):
  - state = IDLE; o_mstb, o_sack, o_serr = 0; o_sdata = 0; timeout counter = 0.
  - o_mcyc is low while i_reset_n is low.
- Pass-through (combinational): o_mwe, o_maddr, o_mdata, o_msel come straight from the classic inputs. The classic master holds these stable until ack, so no registering is needed.
- o_mcyc = i_reset_n && i_scyc && (state != ABORT).
- IDLE:
  - if i_scyc && i_sstb: go to REQ, o_mstb <= 1, clear the counter.
- REQ:
  - o_mstb held high; the request is accepted on the first cycle with !i_mstall.
  - On acceptance: o_mstb <= 0, go to WAIT.
- WAIT:
  - on i_mack || i_merr: o_sack <= i_mack && !i_merr; o_serr <= i_merr; o_sdata <= i_mdata (latched on ack or err); go to ACK.
  - If i_mack and i_merr are high together, err wins.
- ACK:
  - o_sack/o_serr high for exactly one cycle, then cleared; go to IDLE.
  - The classic master still holds its old strobe in this cycle, so no new request is issued from ACK.
  - The next request is seen in IDLE.
- Latency: strobe seen at cycle 0 → o_mstb in cycle 1. With no stall and the slave acking in cycle 2, o_sack is in cycle 3. Every stall cycle and every extra slave wait cycle adds one cycle each.
- Response signals outside WAIT: i_mack/i_merr arriving in IDLE, REQ or ABORT are ignored. They must not pulse o_sack/o_serr.
- Classic abort: i_scyc low in any state → state IDLE next cycle, o_mstb <= 0, o_sack/o_serr <= 0. o_mcyc drops in the same cycle, combinationally, so any outstanding pipelined response is discarded.
- Timeout (LGTIMEOUT > 0):
  - The counter increments every cycle in REQ or WAIT.
  - When it reaches 2^LGTIMEOUT - 1 without a response: o_serr <= 1, o_mstb <= 0, go to ABORT.
  - ABORT lasts one cycle, forces o_mcyc low to flush the pipelined slave, asserts o_serr, then goes to IDLE.
  - The counter saturates and never wraps.
  - If a response and the timeout coincide, the response wins.
- Output invariants:
  - o_sack and o_serr are never high together.
  - At most one pipelined request is outstanding.
  - o_mstb is never high while o_mcyc is low.

Decomposition:
- Shared package wb_bridge_pkg: state encoding constants (IDLE, REQ, WAIT, ACK, ABORT) and the CTI/BTE code constants reused by the other bridges.
- One natural sub-module, wb_timeout_ctr: saturating counter with clear/enable and an expired flag, parameterised by LGTIMEOUT.
- Everything else is inline.

Test Plan:
1. Single read: cyc/stb, we=0, addr 0x123; slave no stall, acks at cycle 2 with data 0xDEADBEEF → o_mstb high only in cycle 1; o_sack pulses in cycle 3 with o_sdata=0xDEADBEEF; exactly one pipelined request.
2. Stalled write: we=1, data 0x5A5A5A5A, sel 0xF; i_mstall high for 3 cycles → o_mstb stays high 4 cycles with stable addr/data; o_sack one cycle after i_mack; no duplicate request.
3. Back-to-back: classic presents a new strobe in the cycle after o_sack → second o_mstb one cycle after IDLE; the two acks are separate single-cycle pulses.
4. Error: slave raises i_merr (with i_mack also high) → o_serr=1 for one cycle, o_sack=0.
5. Abort: i_scyc drops while in WAIT; a late i_mack arrives 2 cycles later → o_mcyc low immediately, no o_sack or o_serr; the next transaction completes normally.
6. Timeout with LGTIMEOUT=4: slave never acks → o_serr at cycle ~16 after issue; o_mcyc low for one ABORT cycle; a late i_mack afterwards is ignored. Also assert reset mid-WAIT → all outputs return to reset values next cycle.
